// File: rtl/timed_event_sched.sv
// timed_event_sched
//   Per-requester delayed event scheduler. Each slot accepts a delay, counts it
//   down, then raises a pending event that is handed to a single consumer
//   through a round-robin arbiter with a valid/ready handshake.
//
// Ports
//   clk         clock, all state updates on rising edge
//   rst_n       synchronous active-low reset
//   req_valid   [NUM_REQ]        requester i offers a delay
//   req_delay   [NUM_REQ*CNT_W]  delay for requester i at [i*CNT_W +: CNT_W]
//   req_ready   [NUM_REQ]        slot i is IDLE and not being cancelled
//   cancel      [NUM_REQ]        abort slot i's outstanding event
//   fire_valid  an expired event is presented
//   fire_id     slot index of the presented event (0 when fire_valid is 0)
//   fire_ready  consumer accepts the presented event
//   busy        at least one slot is not IDLE
//   pend_cnt    number of slots in PEND
//
// Slot FSM
//   state | meaning
//   IDLE  | no event outstanding, can accept a request
//   WAIT  | counting down the requested delay
//   PEND  | delay expired, waiting to be fired or cancelled

module timed_event_sched #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*CNT_W-1:0]   req_delay,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ-1:0]         cancel,
   output logic                       fire_valid,
   output logic [$clog2(NUM_REQ)-1:0] fire_id,
   input  logic                       fire_ready,
   output logic                       busy,
   output logic [$clog2(NUM_REQ):0]   pend_cnt
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int PC_W = ID_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_PEND = 2'd2
   } slot_state_t;

   slot_state_t        state [NUM_REQ];
   logic [CNT_W-1:0]   cnt   [NUM_REQ];
   logic [ID_W-1:0]    rr_ptr;
   // Grant presented last cycle but not taken; keeps fire_id stable under
   // backpressure even if a slot nearer to rr_ptr expires meanwhile.
   logic               hold_vld;
   logic [ID_W-1:0]    hold_id;

   logic [NUM_REQ-1:0] elig;
   logic               grant_vld;
   logic [ID_W-1:0]    grant_id;
   logic               found;
   int                 arb_idx;
   logic               any_busy;
   logic [PC_W-1:0]    pend_sum;

   always_comb begin
      elig     = '0;
      found    = 1'b0;
      arb_idx  = 0;
      grant_id = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = (state[i] == ST_PEND) && !cancel[i];
      end
      grant_vld = rst_n && (|elig);
      if (hold_vld && elig[hold_id]) begin
         grant_id = hold_id;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (!found && elig[arb_idx]) begin
               found    = 1'b1;
               grant_id = ID_W'(arb_idx);
            end
         end
      end
      if (!grant_vld) grant_id = '0;
   end

   // Outputs are forced to their reset values while rst_n is low so that
   // stale pre-reset slot state never shows up on the interface.
   always_comb begin
      req_ready = '1;
      any_busy  = 1'b0;
      pend_sum  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst_n) req_ready[i] = (state[i] == ST_IDLE) && !cancel[i];
         if (state[i] != ST_IDLE) any_busy = 1'b1;
         if (state[i] == ST_PEND) pend_sum = pend_sum + PC_W'(1);
      end
   end

   assign fire_valid = grant_vld;
   assign fire_id    = grant_id;
   assign busy       = rst_n && any_busy;
   assign pend_cnt   = rst_n ? pend_sum : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            state[i] <= ST_IDLE;
            cnt[i]   <= '0;
         end
         rr_ptr   <= '0;
         hold_vld <= 1'b0;
         hold_id  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cancel[i] && (state[i] != ST_IDLE)) begin
               state[i] <= ST_IDLE;
               cnt[i]   <= '0;
            end else begin
               case (state[i])
                  ST_IDLE: begin
                     if (req_valid[i] && !cancel[i]) begin
                        if (req_delay[i*CNT_W +: CNT_W] == '0) begin
                           state[i] <= ST_PEND;
                        end else begin
                           state[i] <= ST_WAIT;
                           cnt[i]   <= req_delay[i*CNT_W +: CNT_W];
                        end
                     end
                  end
                  ST_WAIT: begin
                     if (cnt[i] == CNT_W'(1)) begin
                        state[i] <= ST_PEND;
                        cnt[i]   <= '0;
                     end else begin
                        cnt[i] <= cnt[i] - CNT_W'(1);
                     end
                  end
                  ST_PEND: begin
                     if (grant_vld && fire_ready && (grant_id == ID_W'(i))) begin
                        state[i] <= ST_IDLE;
                     end
                  end
                  default: begin
                     state[i] <= ST_IDLE;
                     cnt[i]   <= '0;
                  end
               endcase
            end
         end

         if (grant_vld && fire_ready) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
         end
         hold_vld <= grant_vld && !fire_ready;
         hold_id  <= grant_id;
      end
   end

endmodule
